// File: rtl/nurn_cfg_mem_mc_if.sv
// ---------------------------------------------------------------------------
// nurn_cfg_mem_mc_if
// Bus bundle for the neuron configuration store / multicast sequencer.
//   cfg_*  : valid/ready configuration write channel (master -> store)
//   fire_* : fire request channel into the multicast sequencer
//   aer_*  : outgoing AER packet stream (valid/ready) from the sequencer
//   seq_done : one-cycle pulse when a fire request has been fully served
// The store connects through the 'slave' modport; the driving environment
// uses 'master'.
// ---------------------------------------------------------------------------
interface nurn_cfg_mem_mc_if #(
   parameter int NID_W         = 8,
   parameter int CFG_AW        = 10,
   parameter int CFG_DW        = 64,
   parameter int AER_BIT_WIDTH = 32
);
   logic                     cfg_valid;
   logic                     cfg_ready;
   logic [2:0]               cfg_sel;
   logic [CFG_AW-1:0]        cfg_addr;
   logic [CFG_DW-1:0]        cfg_data;
   logic                     fire_valid;
   logic [NID_W-1:0]         fire_nid;
   logic                     fire_ready;
   logic                     aer_valid;
   logic [AER_BIT_WIDTH-1:0] aer_data;
   logic                     aer_ready;
   logic                     seq_done;

   modport master (
      output cfg_valid, cfg_sel, cfg_addr, cfg_data, fire_valid, fire_nid, aer_ready,
      input  cfg_ready, fire_ready, aer_valid, aer_data, seq_done
   );

   modport slave (
      input  cfg_valid, cfg_sel, cfg_addr, cfg_data, fire_valid, fire_nid, aer_ready,
      output cfg_ready, fire_ready, aer_valid, aer_data, seq_done
   );
endinterface

// File: rtl/nurn_cfg_mem_mc.sv
// ---------------------------------------------------------------------------
// nurn_cfg_mem_mc
// Per-core neuron configuration store with an autonomous AER multicast
// sequencer.
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   bus (slave)      : config write channel, fire request, AER out stream
//   rdA_*            : STDP parameter read port, 1-cycle latency, holds when idle
//   rdB_*            : neuron parameter read port, 1-cycle latency, holds when idle
//   lm_addr_i / lm_o : learn-mode bit {nid, aid}, 1-cycle latency
//   scl_addr_i/scl_o : per-axon scaling, 1-cycle latency
// Memory contents are not reset; all output registers are.
// ---------------------------------------------------------------------------
module nurn_cfg_mem_mc #(
   parameter int NUM_NURNS          = 256,
   parameter int NUM_AXONS          = 256,
   parameter int DSIZE              = 16,
   parameter int STDP_WIN_BIT_WIDTH = 8,
   parameter int AER_BIT_WIDTH      = 32,
   parameter int AER_DEPTH          = 512,
   parameter int AER_CNT_W          = 4,
   parameter int CFG_DW             = 64,
   localparam int NID_W = $clog2(NUM_NURNS),
   localparam int AID_W = $clog2(NUM_AXONS),
   localparam int PTR_W = $clog2(AER_DEPTH),
   localparam int A_W   = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1,
   localparam int B_W   = 2 + 3*DSIZE + PTR_W + AER_CNT_W
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   nurn_cfg_mem_mc_if.slave       bus,
   input  logic [NID_W-1:0]       rdA_addr_i,
   input  logic                   rdA_en_i,
   output logic [A_W-1:0]         rdA_data_o,
   input  logic [NID_W-1:0]       rdB_addr_i,
   input  logic                   rdB_en_i,
   output logic [B_W-1:0]         rdB_data_o,
   input  logic [NID_W+AID_W-1:0] lm_addr_i,
   output logic                   lm_o,
   input  logic [AID_W-1:0]       scl_addr_i,
   output logic [1:0]             scl_o
);

   localparam int CHUNKS = NUM_AXONS / CFG_DW;
   localparam int CHK_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_READ   = 3'd2,
      S_EMIT   = 3'd3,
      S_DONE   = 3'd4
   } seq_state_e;

   // storage arrays (no reset)
   logic [A_W-1:0]           mem_a   [NUM_NURNS];
   logic [B_W-1:0]           mem_b   [NUM_NURNS];
   logic [AER_BIT_WIDTH-1:0] mem_aer [AER_DEPTH];
   logic [NUM_AXONS-1:0]     mem_lm  [NUM_NURNS];
   logic [1:0]               mem_scl [NUM_AXONS];

   // registered state and outputs
   seq_state_e               state_q,     state_d;
   logic [NID_W-1:0]         nid_q,       nid_d;
   logic [PTR_W-1:0]         ptr_q,       ptr_d;
   logic [AER_CNT_W-1:0]     rem_q,       rem_d;
   logic                     aer_valid_q, aer_valid_d;
   logic [AER_BIT_WIDTH-1:0] aer_data_q,  aer_data_d;
   logic                     seq_done_q,  seq_done_d;
   logic                     fire_rdy_q,  fire_rdy_d;
   logic [A_W-1:0]           rd_a_q,      rd_a_d;
   logic [B_W-1:0]           rd_b_q,      rd_b_d;
   logic                     lm_q,        lm_d;
   logic [1:0]               scl_q,       scl_d;

   // config-bus decode
   logic                     cfg_ready_s;
   logic                     wr_s;
   logic                     we_a_s, we_b_s, we_aer_s, we_lm_s, we_scl_s;
   logic [NID_W-1:0]         lm_nid_s;
   logic [CHK_W-1:0]         lm_chk_s;
   logic [AID_W-1:0]         lm_base_s;

   // Writes to B and the AER table are held off while the sequencer walks them.
   always_comb begin
      cfg_ready_s = 1'b1;
      if (((bus.cfg_sel == 3'd1) || (bus.cfg_sel == 3'd2)) && (state_q != S_IDLE)) begin
         cfg_ready_s = 1'b0;
      end else begin
         cfg_ready_s = 1'b1;
      end
   end

   assign wr_s      = bus.cfg_valid & cfg_ready_s;
   assign lm_nid_s  = bus.cfg_addr[CHK_W +: NID_W];
   assign lm_chk_s  = bus.cfg_addr[CHK_W-1:0];
   assign lm_base_s = AID_W'(lm_chk_s) * AID_W'(CFG_DW);

   // Per-target write enables; reserved selects are accepted but enable nothing.
   always_comb begin
      we_a_s   = 1'b0;
      we_b_s   = 1'b0;
      we_aer_s = 1'b0;
      we_lm_s  = 1'b0;
      we_scl_s = 1'b0;
      case (bus.cfg_sel)
         3'd0:    we_a_s   = wr_s;
         3'd1:    we_b_s   = wr_s;
         3'd2:    we_aer_s = wr_s;
         3'd3:    we_lm_s  = wr_s;
         3'd4:    we_scl_s = wr_s;
         default: we_a_s   = 1'b0;
      endcase
   end

   // Memory array writes.
   always_ff @(posedge clk_i) begin
      if (we_a_s)   mem_a[bus.cfg_addr[NID_W-1:0]]   <= bus.cfg_data[A_W-1:0];
      if (we_b_s)   mem_b[bus.cfg_addr[NID_W-1:0]]   <= bus.cfg_data[B_W-1:0];
      if (we_aer_s) mem_aer[bus.cfg_addr[PTR_W-1:0]] <= bus.cfg_data[AER_BIT_WIDTH-1:0];
      if (we_lm_s)  mem_lm[lm_nid_s][lm_base_s +: CFG_DW] <= bus.cfg_data;
      if (we_scl_s) mem_scl[bus.cfg_addr[AID_W-1:0]] <= bus.cfg_data[1:0];
   end

   // External read ports: A/B hold their last value while not enabled.
   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (rdA_en_i) begin
         rd_a_d = mem_a[rdA_addr_i];
      end else begin
         rd_a_d = rd_a_q;
      end
      if (rdB_en_i) begin
         rd_b_d = mem_b[rdB_addr_i];
      end else begin
         rd_b_d = rd_b_q;
      end
      lm_d  = mem_lm[lm_addr_i[AID_W +: NID_W]][lm_addr_i[AID_W-1:0]];
      scl_d = mem_scl[scl_addr_i];
   end

   // Multicast sequencer next-state and output computation.
   always_comb begin
      state_d     = state_q;
      nid_d       = nid_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      aer_valid_d = aer_valid_q;
      aer_data_d  = aer_data_q;
      seq_done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.fire_valid) begin
               nid_d   = bus.fire_nid;
               state_d = S_LOOKUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOOKUP: begin
            // internal second read of mem B: fan-out pointer and count
            ptr_d   = mem_b[nid_q][AER_CNT_W +: PTR_W];
            rem_d   = mem_b[nid_q][AER_CNT_W-1:0];
            state_d = S_READ;
         end
         S_READ: begin
            if (rem_q == AER_CNT_W'(0)) begin
               seq_done_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               aer_data_d  = mem_aer[ptr_q];
               aer_valid_d = 1'b1;
               state_d     = S_EMIT;
            end
         end
         S_EMIT: begin
            if (bus.aer_ready) begin
               aer_valid_d = 1'b0;
               rem_d       = rem_q - AER_CNT_W'(1);
               if (ptr_q == PTR_W'(AER_DEPTH - 1)) begin
                  ptr_d = PTR_W'(0);
               end else begin
                  ptr_d = ptr_q + PTR_W'(1);
               end
               if (rem_q == AER_CNT_W'(1)) begin
                  seq_done_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end else begin
               state_d = S_EMIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            aer_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
      if (state_d == S_IDLE) begin
         fire_rdy_d = 1'b1;
      end else begin
         fire_rdy_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         nid_q       <= '0;
         ptr_q       <= '0;
         rem_q       <= '0;
         aer_valid_q <= 1'b0;
         aer_data_q  <= '0;
         seq_done_q  <= 1'b0;
         fire_rdy_q  <= 1'b1;
         rd_a_q      <= '0;
         rd_b_q      <= '0;
         lm_q        <= 1'b0;
         scl_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         nid_q       <= nid_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         aer_valid_q <= aer_valid_d;
         aer_data_q  <= aer_data_d;
         seq_done_q  <= seq_done_d;
         fire_rdy_q  <= fire_rdy_d;
         rd_a_q      <= rd_a_d;
         rd_b_q      <= rd_b_d;
         lm_q        <= lm_d;
         scl_q       <= scl_d;
      end
   end

   assign bus.cfg_ready  = cfg_ready_s;
   assign bus.fire_ready = fire_rdy_q;
   assign bus.aer_valid  = aer_valid_q;
   assign bus.aer_data   = aer_data_q;
   assign bus.seq_done   = seq_done_q;
   assign rdA_data_o     = rd_a_q;
   assign rdB_data_o     = rd_b_q;
   assign lm_o           = lm_q;
   assign scl_o          = scl_q;

endmodule

// File: tb/tb_nurn_cfg_mem_mc.sv
// ---------------------------------------------------------------------------
// tb_nurn_cfg_mem_mc
// Scoreboarded bench for nurn_cfg_mem_mc. Inputs change 2 ns after the
// rising edge, outputs are sampled on the falling edge. A packet or done
// pulse visible at a falling edge with edge counter 'cyc' completes at edge
// cyc+1, which is the number stored in the scoreboard (-1 = untimed).
// ---------------------------------------------------------------------------
module tb_nurn_cfg_mem_mc;
   localparam int NID_W  = 8;
   localparam int AID_W  = 8;
   localparam int CFG_AW = 10;
   localparam int CFG_DW = 64;
   localparam int AW     = 32;
   localparam int A_W    = 49;
   localparam int B_W    = 63;
   localparam int PTR_W  = 9;
   localparam int CNT_W  = 4;

   logic clk_i   = 1'b0;
   logic rst_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic [NID_W-1:0]       rdA_addr_i, rdB_addr_i;
   logic                   rdA_en_i, rdB_en_i;
   logic [A_W-1:0]         rdA_data_o;
   logic [B_W-1:0]         rdB_data_o;
   logic [NID_W+AID_W-1:0] lm_addr_i;
   logic                   lm_o;
   logic [AID_W-1:0]       scl_addr_i;
   logic [1:0]             scl_o;

   nurn_cfg_mem_mc_if #(.NID_W(NID_W), .CFG_AW(CFG_AW), .CFG_DW(CFG_DW), .AER_BIT_WIDTH(AW)) bus ();

   nurn_cfg_mem_mc dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .bus        (bus),
      .rdA_addr_i (rdA_addr_i),
      .rdA_en_i   (rdA_en_i),
      .rdA_data_o (rdA_data_o),
      .rdB_addr_i (rdB_addr_i),
      .rdB_en_i   (rdB_en_i),
      .rdB_data_o (rdB_data_o),
      .lm_addr_i  (lm_addr_i),
      .lm_o       (lm_o),
      .scl_addr_i (scl_addr_i),
      .scl_o      (scl_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      logic [AW-1:0] data;
      int            at;
   } exp_t;

   exp_t sb_q[$];
   int   done_q[$];

   // scoreboard monitor: every handshake / done pulse must match a pushed expectation
   always @(negedge clk_i) begin
      exp_t e;
      int   d;
      if (rst_n_i) begin
         if (bus.aer_valid && bus.aer_ready) begin
            if (sb_q.size() == 0) begin
               check_val("aer_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               check_val("aer_data", bus.aer_data, e.data);
               if (e.at >= 0) check_val("aer_time", cyc + 1, e.at);
            end
         end
         if (bus.seq_done) begin
            if (done_q.size() == 0) begin
               check_val("done_unexpected", 64'd1, 64'd0);
            end else begin
               d = done_q.pop_front();
               if (d >= 0) check_val("done_time", cyc + 1, d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic to_cyc(input int tgt);
      while (cyc < tgt) tick();
   endtask

   task automatic cfg_wr(input logic [2:0] sel, input logic [CFG_AW-1:0] addr, input logic [63:0] data);
      bit ok = 1'b0;
      bus.cfg_valid = 1'b1;
      bus.cfg_sel   = sel;
      bus.cfg_addr  = addr;
      bus.cfg_data  = data;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_i);
         if (bus.cfg_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("cfg_timeout", 64'd0, 64'd1);
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic fire(input int nid, output int t);
      t = -1;
      bus.fire_valid = 1'b1;
      bus.fire_nid   = NID_W'(nid);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_i);
         if (bus.fire_ready) begin
            t = cyc + 1;
            break;
         end
      end
      if (t < 0) check_val("fire_timeout", 64'd0, 64'd1);
      tick();
      bus.fire_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_i);
         if (bus.fire_ready && (sb_q.size() == 0) && (done_q.size() == 0)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("idle_timeout", 64'd0, 64'd1);
      tick();
   endtask

   task automatic push_pkt(input logic [AW-1:0] data, input int at);
      exp_t e;
      e.data = data;
      e.at   = at;
      sb_q.push_back(e);
   endtask

   function automatic logic [63:0] b_entry(input int ptr, input int cnt, input logic [15:0] fth);
      logic [B_W-1:0] b;
      b = '0;
      b[CNT_W-1:0]            = cnt[CNT_W-1:0];
      b[CNT_W +: PTR_W]       = ptr[PTR_W-1:0];
      b[CNT_W+PTR_W +: 16]    = fth;
      return {1'b0, b};
   endfunction

   task automatic rd_a(input int addr);
      rdA_en_i   = 1'b1;
      rdA_addr_i = NID_W'(addr);
      tick();
      rdA_en_i   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [A_W-1:0] a5, a5b, a33;
      int t;

      bus.cfg_valid  = 1'b0;
      bus.cfg_sel    = 3'd0;
      bus.cfg_addr   = '0;
      bus.cfg_data   = '0;
      bus.fire_valid = 1'b0;
      bus.fire_nid   = '0;
      bus.aer_ready  = 1'b1;
      rdA_addr_i = '0; rdA_en_i = 1'b0;
      rdB_addr_i = '0; rdB_en_i = 1'b0;
      lm_addr_i  = '0; scl_addr_i = '0;

      repeat (3) @(posedge clk_i);
      #2 rst_n_i = 1'b1;

      // reset state
      @(negedge clk_i);
      check_val("rst_rdA", rdA_data_o, 64'd0);
      check_val("rst_rdB", rdB_data_o, 64'd0);
      check_val("rst_lm", lm_o, 64'd0);
      check_val("rst_scl", scl_o, 64'd0);
      check_val("rst_aer_valid", bus.aer_valid, 64'd0);
      check_val("rst_aer_data", bus.aer_data, 64'd0);
      check_val("rst_seq_done", bus.seq_done, 64'd0);
      check_val("rst_fire_ready", bus.fire_ready, 64'd1);
      check_val("rst_cfg_ready", bus.cfg_ready, 64'd1);
      tick();

      // mem A write, read, hold
      a5 = {8'h10, 8'h20, 16'h0100, 16'h0080, 1'b1};
      cfg_wr(3'd0, 10'd5, {15'd0, a5});
      rdA_en_i = 1'b1; rdA_addr_i = 8'd5;
      tick();
      rdA_en_i = 1'b0; rdA_addr_i = 8'd6;
      @(negedge clk_i);
      check_val("rdA_5", rdA_data_o, {15'd0, a5});
      tick();
      @(negedge clk_i);
      check_val("rdA_hold", rdA_data_o, {15'd0, a5});
      tick();

      // same-cycle write and read of A[5] returns old data
      a5b = {8'h55, 8'h66, 16'h1234, 16'h4321, 1'b0};
      bus.cfg_valid = 1'b1; bus.cfg_sel = 3'd0; bus.cfg_addr = 10'd5; bus.cfg_data = {15'd0, a5b};
      rdA_en_i = 1'b1; rdA_addr_i = 8'd5;
      tick();
      bus.cfg_valid = 1'b0;
      @(negedge clk_i);
      check_val("rdA_old_on_collide", rdA_data_o, {15'd0, a5});
      tick();
      rdA_en_i = 1'b0;
      @(negedge clk_i);
      check_val("rdA_new_after", rdA_data_o, {15'd0, a5b});
      tick();

      // basic multicast: B[7] ptr=3 cnt=3
      cfg_wr(3'd1, 10'd7, b_entry(3, 3, 16'hBEEF));
      cfg_wr(3'd2, 10'd3, 64'hA);
      cfg_wr(3'd2, 10'd4, 64'hB);
      cfg_wr(3'd2, 10'd5, 64'hC);
      rdB_en_i = 1'b1; rdB_addr_i = 8'd7;
      tick();
      rdB_en_i = 1'b0;
      @(negedge clk_i);
      check_val("rdB_7", rdB_data_o, b_entry(3, 3, 16'hBEEF));
      tick();
      fire(7, t);
      push_pkt(32'hA, t + 3);
      push_pkt(32'hB, t + 5);
      push_pkt(32'hC, t + 7);
      done_q.push_back(t + 8);
      to_cyc(t + 2);
      @(negedge clk_i);
      check_val("fire_ready_busy", bus.fire_ready, 64'd0);
      to_cyc(t + 7);
      @(negedge clk_i);
      check_val("fire_ready_in_done", bus.fire_ready, 64'd0);
      to_cyc(t + 8);
      @(negedge clk_i);
      check_val("fire_ready_back", bus.fire_ready, 64'd1);
      wait_idle();

      // pointer wrap: ptr=511 cnt=2
      cfg_wr(3'd2, 10'd511, 64'h5110_0001);
      cfg_wr(3'd2, 10'd0, 64'h0000_0AA0);
      cfg_wr(3'd1, 10'd8, b_entry(511, 2, 16'h0));
      fire(8, t);
      push_pkt(32'h5110_0001, t + 3);
      push_pkt(32'h0000_0AA0, t + 5);
      done_q.push_back(t + 6);
      wait_idle();

      // zero fan-out
      cfg_wr(3'd1, 10'd9, b_entry(10, 0, 16'h0));
      fire(9, t);
      done_q.push_back(t + 3);
      wait_idle();

      // downstream stall, cfg writes during sequence
      cfg_wr(3'd2, 10'd20, 64'h2000_0020);
      cfg_wr(3'd2, 10'd21, 64'h2000_0021);
      cfg_wr(3'd2, 10'd22, 64'h2000_0022);
      cfg_wr(3'd1, 10'd10, b_entry(20, 3, 16'h0));
      fire(10, t);
      push_pkt(32'h2000_0020, t + 3);
      push_pkt(32'h2000_0021, -1);
      push_pkt(32'h2000_0022, -1);
      done_q.push_back(-1);
      to_cyc(t + 3);
      bus.aer_ready = 1'b0;
      to_cyc(t + 4);
      bus.cfg_valid = 1'b1; bus.cfg_sel = 3'd2; bus.cfg_addr = 10'd100; bus.cfg_data = 64'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check_val("stall_valid", bus.aer_valid, 64'd1);
         check_val("stall_data", bus.aer_data, 64'h2000_0021);
         check_val("stall_cfg_ready", bus.cfg_ready, 64'd0);
         tick();
      end
      a33 = {8'h33, 8'h44, 16'hCAFE, 16'hF00D, 1'b1};
      bus.cfg_sel = 3'd0; bus.cfg_addr = 10'd33; bus.cfg_data = {15'd0, a33};
      @(negedge clk_i);
      check_val("seq_cfg_a_ready", bus.cfg_ready, 64'd1);
      tick();
      bus.cfg_valid = 1'b0;
      bus.aer_ready = 1'b1;
      cfg_wr(3'd2, 10'd100, 64'h77);
      wait_idle();
      rd_a(33);
      @(negedge clk_i);
      check_val("rdA_33", rdA_data_o, {15'd0, a33});
      tick();
      cfg_wr(3'd1, 10'd11, b_entry(100, 1, 16'h0));
      fire(11, t);
      push_pkt(32'h77, t + 3);
      done_q.push_back(t + 4);
      wait_idle();

      // learn-mode and scaling
      cfg_wr(3'd3, {8'd1, 2'd2}, 64'h1);
      cfg_wr(3'd3, {8'd1, 2'd3}, 64'h8000_0000_0000_0000);
      lm_addr_i = {8'd1, 8'd128};
      tick();
      @(negedge clk_i);
      check_val("lm_1_128", lm_o, 64'd1);
      lm_addr_i = {8'd1, 8'd129};
      tick();
      @(negedge clk_i);
      check_val("lm_1_129", lm_o, 64'd0);
      lm_addr_i = {8'd1, 8'd255};
      tick();
      @(negedge clk_i);
      check_val("lm_1_255", lm_o, 64'd1);
      cfg_wr(3'd4, 10'd17, 64'hFFFF_FFFF_FFFF_FFF6);
      cfg_wr(3'd4, 10'd18, 64'h1);
      scl_addr_i = 8'd17;
      tick();
      @(negedge clk_i);
      check_val("scl_17", scl_o, 64'd2);
      scl_addr_i = 8'd18;
      tick();
      @(negedge clk_i);
      check_val("scl_18", scl_o, 64'd1);
      tick();

      // reserved select accepted and discarded
      bus.cfg_valid = 1'b1; bus.cfg_sel = 3'd5; bus.cfg_addr = 10'd5; bus.cfg_data = 64'hDEAD;
      @(negedge clk_i);
      check_val("rsvd_ready", bus.cfg_ready, 64'd1);
      tick();
      bus.cfg_valid = 1'b0;
      rd_a(5);
      @(negedge clk_i);
      check_val("rsvd_no_effect", rdA_data_o, {15'd0, a5b});
      tick();

      // reset during EMIT
      cfg_wr(3'd2, 10'd30, 64'h3030_3030);
      cfg_wr(3'd1, 10'd12, b_entry(30, 2, 16'h0));
      bus.aer_ready = 1'b0;
      fire(12, t);
      to_cyc(t + 2);
      @(negedge clk_i);
      check_val("emit_valid_pre_rst", bus.aer_valid, 64'd1);
      #1 rst_n_i = 1'b0;
      #1;
      check_val("rst_async_valid", bus.aer_valid, 64'd0);
      check_val("rst_async_fire_ready", bus.fire_ready, 64'd1);
      tick();
      rst_n_i = 1'b1;
      bus.aer_ready = 1'b1;
      @(negedge clk_i);
      check_val("post_rst_valid", bus.aer_valid, 64'd0);
      check_val("post_rst_fire_ready", bus.fire_ready, 64'd1);
      tick();
      fire(7, t);
      push_pkt(32'hA, t + 3);
      push_pkt(32'hB, t + 5);
      push_pkt(32'hC, t + 7);
      done_q.push_back(t + 8);
      wait_idle();

      check_val("sb_empty", sb_q.size(), 64'd0);
      check_val("done_empty", done_q.size(), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nurn_cfg_mem_mc.md
Name: nurn_cfg_mem_mc

Overview:
Parametrised per-core neuron configuration store for the SNN router tile.
- Holds STDP parameters (mem A), neuron parameters (mem B), per-(neuron,axon) learn-mode bits, per-axon scaling, and a linked AER fan-out table.
- Adds a valid/ready config-write bus.
- Adds an autonomous multicast sequencer: on a neuron fire request it emits every AER destination packet for that neuron with a valid/ready handshake.

Parameters:
NUM_NURNS, 256, neurons per core; NID_W = clog2(NUM_NURNS)
NUM_AXONS, 256, axons per core, multiple of CFG_DW; AID_W = clog2(NUM_AXONS)
DSIZE, 16, datapath width
STDP_WIN_BIT_WIDTH, 8, LTP/LTD window width
AER_BIT_WIDTH, 32, AER packet width
AER_DEPTH, 512, AER table entries; PTR_W = clog2(AER_DEPTH)
AER_CNT_W, 4, fan-out count width per neuron
CFG_DW, 64, config data width; must be at least A_W and B_W

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
cfg_valid_i  in  1  config write request
cfg_ready_o  out  1  config write accepted when valid&ready
cfg_sel_i  in  3  target: 0=A, 1=B, 2=AER, 3=learn-mode chunk, 4=axon scaling; 5-7 reserved
cfg_addr_i  in  max(NID_W+clog2(NUM_AXONS/CFG_DW), PTR_W, AID_W)  entry address
cfg_data_i  in  CFG_DW  write data, LSB-aligned
rdA_addr_i  in  NID_W  mem A read address
rdA_en_i  in  1  mem A read enable
rdA_data_o  out  A_W  {LTP_win, LTD_win, LTP_rate, LTD_rate, bias_mode}; A_W = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1
rdB_addr_i  in  NID_W  mem B read address
rdB_en_i  in  1  mem B read enable
rdB_data_o  out  B_W  {type, rand_th, th_mask, rst_pot, fixed_th, aer_ptr[PTR_W], aer_cnt[AER_CNT_W]}; B_W = 2 + 3*DSIZE + PTR_W + AER_CNT_W
lm_addr_i  in  NID_W+AID_W  {nid, aid} learn-mode bit address
lm_o  out  1  learn-mode bit
scl_addr_i  in  AID_W  axon scaling address
scl_o  out  2  axon scaling
fire_valid_i  in  1  fire request
fire_nid_i  in  NID_W  firing neuron
fire_ready_o  out  1  sequencer idle
aer_valid_o  out  1  outgoing packet valid
aer_data_o  out  AER_BIT_WIDTH  packet
aer_ready_i  in  1  downstream accept
seq_done_o  out  1  one-cycle pulse when a fire request completes

Behaviour:
- Reset: all output registers 0; FSM to IDLE; fire_ready_o=1; cfg_ready_o=1. Memory contents are not reset.
- Config writes take effect at the accepting clock edge and are visible to reads issued in the next cycle.
- cfg_ready_o = 0 when cfg_sel_i is 1 or 2 and the FSM is not IDLE; 1 otherwise.
- Writes to reserved selects are accepted and discarded.
- Learn-mode writes store cfg_data_i as bits [chunk*CFG_DW +: CFG_DW] of neuron nid's NUM_AXONS-bit row, where cfg_addr_i = {nid, chunk}.
- Axon scaling writes store cfg_data_i[1:0].
- Read ports A/B: 1-cycle latency. The en-high cycle updates rdX_data_o at the next edge; the output holds while en is low.
- lm_o and scl_o: unconditional 1-cycle latency.
- Sequencer FSM:
  - IDLE: fire_ready_o=1; on fire_valid_i latch nid, go to LOOKUP.
  - LOOKUP: issue mem B read on an internal second read port; go to READ.
  - READ: if aer_cnt==0, go to DONE. Otherwise issue AER read at ptr, go to EMIT.
  - EMIT: aer_valid_o=1 and aer_data_o stay stable until aer_ready_i. On handshake, decrement remaining and advance ptr = (ptr+1) mod AER_DEPTH (wrap at AER_DEPTH-1 to 0). If remaining becomes 0, go to DONE; else go to READ.
  - DONE: seq_done_o=1 for one cycle, then IDLE.
- Sequencer timing: accept at T, first aer_valid_o at T+3; throughput is one packet per 2 cycles with ready held high.
- A fire request while not IDLE is not accepted; fire_ready_o=0.
- Reset mid-sequence: aer_valid_o drops immediately (asynchronous); the pending packet is lost.
- Config write to mem A or scaling during a sequence: allowed.
- Same-address write and read in the same cycle: the read returns the old data.

Test Plan:
- Write A[5] = {8'h10, 8'h20, 16'h0100, 16'h0080, 1} via cfg bus, then rdA_en with addr 5 -> rdA_data_o equals the written value one cycle later and holds when en drops.
- B[7]: ptr=3, cnt=3; AER[3..5]=0xA,0xB,0xC; fire nid 7 at T, ready held high -> packets 0xA@T+3, 0xB@T+5, 0xC@T+7; seq_done_o@T+8; fire_ready_o high @T+9.
- ptr=AER_DEPTH-1, cnt=2 -> emits AER[511] then AER[0] (wrap).
- cnt=0 -> no aer_valid_o; seq_done_o @T+3.
- aer_ready_i low for 4 cycles mid-stream -> data stable; cfg write sel=2 stalls (cfg_ready_o=0) until IDLE; sel=0 accepted.
- Learn-mode chunk 2 of nid 1 = 64'h1 -> lm_addr {1,128} gives lm_o=1 and {1,129} gives 0. Assert reset during EMIT -> aer_valid_o=0 and FSM IDLE.
